cart_bank_mapper: RTL

CART_BANK_MAPPER -- requirements
Module: cart_bank_mapper

---
 rtl/cart_bank_mapper.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cart_bank_mapper.sv
// Cartridge bank mapper: ROM/RAM bank selection driven by either the PC pins or
// a lockable register window at 0x7F00-0x7F03 that unlocks with a two-byte key.
module cart_bank_mapper #(
    parameter int ROM_AW = 17,
    parameter int RAM_AW = 13
) (
    input  logic              CLK,
    input  logic              RESB,
    input  logic              CE,
    input  logic              MODE,
    input  logic [14:0]       A,
    input  logic [7:0]        DI,
    input  logic              RDB,
    input  logic              WRB,
    input  logic              CSB,
    input  logic [1:0]        PC,
    output logic [ROM_AW-1:0] ROM_A,
    output logic              ROM_CSB,
    output logic [RAM_AW-1:0] RAM_A,
    output logic              RAM_CSB,
    output logic              RAM_WEB,
    output logic [7:0]        DO,
    output logic              DOE
);

    localparam int BW  = ROM_AW - 15;
    localparam int RBW = RAM_AW - 13;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        HALF     = 2'd1,
        UNLOCKED = 2'd2
    } lock_state_e;

    lock_state_e   state_q, state_d;
    logic          wrb_q;
    logic [BW-1:0] bank_q, bank_d;
    logic [1:0]    ramctl_q, ramctl_d;
    logic [BW-1:0] rom_pc_s;
    logic [7:0]    rambank_rd_s;
    logic          reg_win_s, reg_hit_s, strobe_s, key_wr_s, cfg_wr_s, ram_sel_s;

    assign reg_win_s = (A[14:8] == 7'h7F) && (A[7:2] == 6'd0);
    assign reg_hit_s = reg_win_s & MODE;
    // One strobe per WRB falling edge, as seen through CE-qualified sampling.
    assign strobe_s  = wrb_q & ~WRB & ~CSB;
    assign key_wr_s  = strobe_s & reg_win_s & (A[1:0] == 2'd3);
    assign cfg_wr_s  = strobe_s & reg_win_s & MODE & (state_q == UNLOCKED);

    // Lock FSM next-state: 5A then A5 unlocks, 00 relocks.
    always_comb begin
        state_d = state_q;
        if (key_wr_s) begin
            case (state_q)
                LOCKED:   state_d = (DI == 8'h5A) ? HALF : LOCKED;
                HALF:     state_d = (DI == 8'hA5) ? UNLOCKED : LOCKED;
                UNLOCKED: state_d = (DI == 8'h00) ? LOCKED : UNLOCKED;
                default:  state_d = LOCKED;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Bank/control register next-state.
    always_comb begin
        bank_d   = bank_q;
        ramctl_d = ramctl_q;
        if (cfg_wr_s && (A[1:0] == 2'd0)) begin
            bank_d = DI[BW-1:0];
        end else if (cfg_wr_s && (A[1:0] == 2'd1)) begin
            ramctl_d = DI[1:0];
        end else begin
            bank_d   = bank_q;
            ramctl_d = ramctl_q;
        end
    end

    // State registers, frozen while CE is low.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state_q  <= LOCKED;
            wrb_q    <= 1'b1;
            bank_q   <= '0;
            ramctl_q <= 2'd0;
        end else if (CE) begin
            state_q  <= state_d;
            wrb_q    <= WRB;
            bank_q   <= bank_d;
            ramctl_q <= ramctl_d;
        end
    end

    generate
        if (RBW > 0) begin : g_rambank
            logic [RBW-1:0] rambank_q, rambank_d;

            // RAM bank register next-state.
            always_comb begin
                rambank_d = rambank_q;
                if (cfg_wr_s && (A[1:0] == 2'd2)) begin
                    rambank_d = DI[RBW-1:0];
                end else begin
                    rambank_d = rambank_q;
                end
            end

            // RAM bank register.
            always_ff @(posedge CLK or negedge RESB) begin
                if (!RESB) begin
                    rambank_q <= '0;
                end else if (CE) begin
                    rambank_q <= rambank_d;
                end
            end

            assign RAM_A        = {rambank_q, A[12:0]};
            assign rambank_rd_s = {{(8-RBW){1'b0}}, rambank_q};
        end else begin : g_no_rambank
            assign RAM_A        = A[12:0];
            assign rambank_rd_s = 8'd0;
        end

        if (BW == 1) begin : g_pc1
            assign rom_pc_s = PC[0];
        end else if (BW == 2) begin : g_pc2
            assign rom_pc_s = PC;
        end else begin : g_pcn
            assign rom_pc_s = {{(BW-2){1'b0}}, PC};
        end
    endgenerate

    assign ROM_A     = {(MODE ? bank_q : rom_pc_s), A};
    assign ram_sel_s = MODE & ramctl_q[0] & (A[14:13] == 2'b11) & ~reg_win_s;
    assign ROM_CSB   = CSB | ram_sel_s | reg_hit_s;
    assign RAM_CSB   = CSB | ~ram_sel_s;
    assign RAM_WEB   = WRB | RAM_CSB | ~ramctl_q[1];
    assign DOE       = ~CSB & ~RDB & reg_hit_s;

    // Register read-back mux.
    always_comb begin
        DO = 8'd0;
        case (A[1:0])
            2'd0:    DO = {{(8-BW){1'b0}}, bank_q};
            2'd1:    DO = {6'd0, ramctl_q};
            2'd2:    DO = rambank_rd_s;
            2'd3:    DO = {6'd0, state_q};
            default: DO = 8'd0;
        endcase
    end

endmodule
